// File: rtl/morse_beep_sequencer_pkg.sv
// Shared types and constants for the Morse beep sequencer.
// mark_ticks gives the length of one mark in clk_lc ticks.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DOT_TICKS_DEF = 4;
  localparam int DASH_MULT_DEF = 3;
  localparam int MAX_LEN_DEF   = 5;

  function automatic int mark_ticks(input logic dash,
                                    input int dot_ticks = DOT_TICKS_DEF,
                                    input int dash_mult = DASH_MULT_DEF);
    return dash ? dot_ticks * dash_mult : dot_ticks;
  endfunction

endpackage

// File: rtl/morse_beep_sequencer_if.sv
// Character request / status bundle between the encoder FSM (master) and the sequencer (slave).
interface morse_beep_sequencer_if #(
  parameter int MAX_LEN = 5,
  parameter int LEN_W   = 3
);
  logic               start;
  logic [LEN_W-1:0]   sym_len;
  logic [MAX_LEN-1:0] sym_bits;
  logic               busy;
  logic               beep_en;
  logic               done;

  modport master (output start, sym_len, sym_bits, input busy, beep_en, done);
  modport slave  (input start, sym_len, sym_bits, output busy, beep_en, done);
endinterface

// File: rtl/morse_beep_sequencer_tick_counter.sv
// Loadable down-counter with zero flag; times both marks and spaces.
// Load value is (ticks - 1) so that a loaded period spans exactly 'ticks' cycles.
module morse_tick_counter #(
  parameter int W = 4
) (
  input  logic         clk_lc,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_lc or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/morse_beep_sequencer.sv
// Plays one latched Morse character as a timed beep_en gate on the tick clock clk_lc.
// All status outputs are registered; start is only honoured in IDLE.
module morse_beep_sequencer
  import morse_pkg::*;
#(
  parameter int DOT_TICKS = DOT_TICKS_DEF,
  parameter int DASH_MULT = DASH_MULT_DEF,
  parameter int MAX_LEN   = MAX_LEN_DEF,
  parameter int LEN_W     = 3,
  parameter int CNT_W     = $clog2(DASH_MULT * DOT_TICKS + 1)
) (
  input  logic                  clk_lc,
  input  logic                  rst,
  morse_beep_sequencer_if.slave bus
);

  state_e             state_q;
  logic [MAX_LEN-1:0] bits_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx_q;
  logic               busy_q, beep_en_q, done_q;

  logic [LEN_W-1:0]   len_c;
  logic [LEN_W-1:0]   next_idx;
  logic [MAX_LEN-1:0] bits_shift;
  logic               more_elems;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_zero;

  assign len_c      = (bus.sym_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.sym_len;
  assign next_idx   = idx_q + 1'b1;
  assign more_elems = (next_idx < len_q);
  assign bits_shift = bits_q >> next_idx;

  // Counter is reloaded on every entry into MARK or SPACE.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      IDLE: if (bus.start && len_c != '0) begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(mark_ticks(bus.sym_bits[0], DOT_TICKS, DASH_MULT) - 1);
      end
      MARK: if (cnt_zero && more_elems) begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(DOT_TICKS - 1);
      end
      SPACE: if (cnt_zero) begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(mark_ticks(bits_shift[0], DOT_TICKS, DASH_MULT) - 1);
      end
      default: ;
    endcase
  end

  morse_tick_counter #(.W(CNT_W)) u_tick_counter (
    .clk_lc     (clk_lc),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_lc or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bits_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      beep_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            bits_q <= bus.sym_bits;
            len_q  <= len_c;
            idx_q  <= '0;
            busy_q <= 1'b1;
            if (len_c == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= MARK;
              beep_en_q <= 1'b1;
            end
          end
        end
        MARK: if (cnt_zero) begin
          beep_en_q <= 1'b0;
          if (more_elems) begin
            state_q <= SPACE;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        SPACE: if (cnt_zero) begin
          idx_q     <= next_idx;
          state_q   <= MARK;
          beep_en_q <= 1'b1;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.beep_en = beep_en_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_morse_beep_sequencer.sv
// Directed bench for morse_beep_sequencer: per-cycle {busy,beep_en,done} against a timing schedule.
module tb_morse_beep_sequencer;
  import morse_pkg::*;

  logic clk_lc = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  int   done_at;

  always #5 clk_lc = ~clk_lc;

  morse_beep_sequencer_if bus ();

  morse_beep_sequencer dut (
    .clk_lc (clk_lc),
    .rst    (rst),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected {busy,beep_en,done} in cycle c after the start edge (cycle 1 follows E0).
  function automatic logic [2:0] expect_at(input int c, input int len, input logic [4:0] bits);
    int L;
    int t;
    int m;
    L = (len > 5) ? 5 : len;
    t = 1;
    for (int i = 0; i < L; i++) begin
      m = bits[i] ? 12 : 4;
      if (c >= t && c < t + m) return 3'b110;
      t += m;
      if (i < L - 1) begin
        if (c >= t && c < t + 4) return 3'b100;
        t += 4;
      end
    end
    if (c == t) return 3'b101;
    return 3'b000;
  endfunction

  function automatic logic [31:0] outs();
    return {29'b0, bus.busy, bus.beep_en, bus.done};
  endfunction

  // Drives a start pulse for edge E0 and returns at the cycle-1 sample point.
  task automatic start_char(input int len, input logic [4:0] bits, input bit hold);
    @(negedge clk_lc);
    bus.start    = 1'b1;
    bus.sym_len  = 3'(len);
    bus.sym_bits = bits;
    @(posedge clk_lc);
    @(negedge clk_lc);
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic play(input string tag, input int len, input logic [4:0] bits,
                      input int ncyc, input bit disturb, output int first_done);
    first_done = 0;
    start_char(len, bits, 1'b0);
    for (int c = 1; c <= ncyc; c++) begin
      chk($sformatf("%s_c%0d", tag, c), outs(), 32'(expect_at(c, len, bits)));
      if (bus.done && first_done == 0) first_done = c;
      if (disturb && c == 3) begin
        bus.start    = 1'b1;
        bus.sym_len  = 3'd5;
        bus.sym_bits = ~bits;
      end
      if (disturb && c == 4) bus.start = 1'b0;
      @(negedge clk_lc);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.sym_len  = '0;
    bus.sym_bits = '0;
    #2;
    chk("reset_outs", outs(), 32'h0);
    @(negedge clk_lc);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("idle_c%0d", c), outs(), 32'h0);
      @(negedge clk_lc);
    end

    play("A", 2, 5'b00010, 25, 1'b0, done_at);
    chk("A_done_cycle", 32'(done_at), 32'd21);

    play("len0", 0, 5'b10101, 4, 1'b0, done_at);
    chk("len0_done_cycle", 32'(done_at), 32'd1);

    play("clamp7", 7, 5'b11111, 80, 1'b0, done_at);
    chk("clamp7_done_cycle", 32'(done_at), 32'd77);

    // Upper bits beyond len must not be played.
    play("R", 3, 5'b11010, 32, 1'b0, done_at);
    chk("R_done_cycle", 32'(done_at), 32'd29);

    play("A_dup_start", 2, 5'b00010, 25, 1'b1, done_at);
    chk("A_dup_done_cycle", 32'(done_at), 32'd21);

    // start held high: one IDLE cycle, then the next character's mark.
    start_char(2, 5'b00010, 1'b1);
    for (int c = 1; c <= 22; c++) begin
      chk($sformatf("b2b_c%0d", c), outs(), 32'(expect_at(c, 2, 5'b00010)));
      @(negedge clk_lc);
    end
    chk("b2b_c23", outs(), 32'b110);
    bus.start = 1'b0;
    for (int c = 0; c < 25; c++) @(negedge clk_lc);
    chk("b2b_idle", outs(), 32'h0);

    // Reset in the middle of the dash of 'A'.
    start_char(2, 5'b00010, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      if (c < 10) @(negedge clk_lc);
    end
    chk("mid_dash_c10", outs(), 32'b110);
    #1 rst = 1'b1;
    #1 chk("async_rst_outs", outs(), 32'h0);
    @(negedge clk_lc);
    rst = 1'b0;
    chk("post_rst_idle", outs(), 32'h0);
    play("A_after_rst", 2, 5'b00010, 25, 1'b0, done_at);
    chk("A_after_rst_done_cycle", 32'(done_at), 32'd21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/morse_beep_sequencer.md
Name: morse_beep_sequencer

Overview:
Converts one Morse character code (dot/dash pattern plus element count) into a timed gate signal, beep_en, which enables the downstream tone buzzer stage. Runs on the slow timing clock clk_lc, where one clk_lc cycle is one timing tick. It sits between the character encoder/control FSM (upstream, start/done handshake) and the buzzer stage (downstream, beep_en gates the toggling tone output).

Parameters:
DOT_TICKS, 4, clk_lc cycles per dot mark and per intra-character space; must be at least 1.
DASH_MULT, 3, dash mark length as a multiple of DOT_TICKS.
MAX_LEN, 5, maximum number of elements per character.
LEN_W, 3, width of sym_len.
CNT_W, derived as clog2(DASH_MULT*DOT_TICKS+1), width of the tick counter.

Ports:
clk_lc  input  1  timing clock; all state changes on its rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request to play a character; sampled only in IDLE
sym_len  input  LEN_W  element count, 0..7; values above MAX_LEN are clamped to MAX_LEN
sym_bits  input  MAX_LEN  element pattern; bit0 is played first; 1 = dash, 0 = dot
busy  output  1  high while state is not IDLE
beep_en  output  1  high during a mark; drives the buzzer gate
done  output  1  one-cycle pulse when the character has finished

Behaviour:
- Reset is asynchronous, active-high, on clock clk_lc. On reset: state=IDLE, busy=0, beep_en=0, done=0, counters=0, latched symbol=0. Reset asserted mid-character aborts immediately, and beep_en falls asynchronously.
- All outputs are registered, with no combinational paths from inputs to outputs.
- State machine states: IDLE, MARK, SPACE, DONE.
- IDLE: on an edge E0 with start=1, latch sym_bits, latch the clamped sym_len, and set elem_idx=0.
  - If the clamped length is 0, go to DONE.
  - Otherwise go to MARK with tick count N = DOT_TICKS (dot) or DASH_MULT*DOT_TICKS (dash), taken from latched bit0.
- MARK: beep_en=1 for exactly N cycles.
  - When the last tick expires and elem_idx+1 < len, go to SPACE for DOT_TICKS cycles.
  - Otherwise go to DONE.
- SPACE: beep_en=0 for DOT_TICKS cycles, then increment elem_idx and go to MARK with N for the next bit.
- DONE: lasts one cycle with done=1 and beep_en=0, then returns to IDLE.
- busy=1 in MARK, SPACE and DONE.
- start is ignored while busy. Inputs are not re-sampled mid-character, because the latched copy is used.
- start held high continuously makes characters play back-to-back, with one IDLE cycle between done and the next MARK. There is no inter-character gap; the upstream block inserts it.
- Bits of sym_bits at or above len are ignored.
- Latency: beep_en rises one cycle after the start edge.
- Total busy cycles = sum of marks + (len-1)*DOT_TICKS + 1.

Decomposition:
- Shared package morse_pkg holds:
  - the state enum (IDLE, MARK, SPACE, DONE);
  - constants DOT_TICKS_DEF=4, DASH_MULT_DEF=3, MAX_LEN_DEF=5;
  - a function mark_ticks(bit) returning the mark length.
- One natural sub-module: morse_tick_counter, a loadable down-counter with a zero flag used for both mark and space timing. Everything else stays in the top module.

Test Plan:
- Reset, then hold start=0 -> busy=0, beep_en=0, done=0 indefinitely.
- 'A' (sym_len=2, sym_bits=5'b00010), DOT_TICKS=4, start pulse at E0:
  - beep_en=1 for cycles 1-4, 0 for cycles 5-8, 1 for cycles 9-20;
  - done=1 in cycle 21 only;
  - busy=1 for cycles 1-21, then 0.
- sym_len=0 -> busy=1 and done=1 in cycle 1 only; beep_en never rises.
- sym_len=7 with sym_bits=5'b11111 -> clamped to 5 dashes: 5x12 high, 4x4 low, done at cycle 77.
- Second start pulse during a mark, with different sym_bits -> ignored; waveform identical to the single-start case.
- rst asserted mid-dash (cycle 10 of 'A') -> beep_en, busy and done go to 0 immediately. After release, a fresh start plays 'A' from the beginning with unchanged timing.
